seg_scan_driver: RTL and testbench

- Downstream consumer of the minute/second BCD counter chain.
- Takes the four decoded 7-segment digit patterns plus the counter's finish flag, and time-multiplexes them onto one shared segment bus with per-digit select lines.
- Adds anti-ghosting blanking between digit slots, and blinks the whole display while the finish flag is held.

---
 rtl/seg_scan_driver.sv | 105 ++++++++++
 tb/tb_seg_scan_driver.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scanner with anti-ghosting blanking and
// whole-display blink driven by the counter's finish flag.
module seg_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_GUARD    = 2,
  parameter int BLINK_DIV      = 125,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [0:3][7:0] hex,
  input  logic            blink_en,
  output logic [7:0]      seg,
  output logic [3:0]      dig_sel,
  output logic [1:0]      digit_idx,
  output logic            frame_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FC_W  = $clog2(BLINK_DIV + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD    = DIV_W'(BLANK_GUARD);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_DIV);
  localparam logic [7:0]       SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0]       DIG_MASK = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  typedef enum logic {PH_ON, PH_OFF} phase_t;

  // started distinguishes the held-in-reset cycle from div=0 of the first slot
  logic             started;
  logic [DIV_W-1:0] div, div_n;
  logic [1:0]       idx_n;
  logic [FC_W-1:0]  frame_cnt, fcnt_n, fcnt_inc;
  phase_t           phase, phase_n;
  logic             slot_start;
  logic             tick_n;
  logic [3:0]       sel_n;

  assign fcnt_inc = frame_cnt + 1'b1;

  always_comb begin
    slot_start = 1'b0;
    div_n      = div;
    idx_n      = digit_idx;
    if (!started) begin
      slot_start = 1'b1;
      div_n      = '0;
      idx_n      = 2'd0;
    end else if (div == DIV_LAST) begin
      slot_start = 1'b1;
      div_n      = '0;
      idx_n      = digit_idx + 2'd1;
    end else begin
      div_n      = div + 1'b1;
    end
  end

  // Phase only moves on a slot start, so a lit digit is never cut short.
  always_comb begin
    fcnt_n  = frame_cnt;
    phase_n = phase;
    if (!blink_en) begin
      fcnt_n = '0;
      if (slot_start) phase_n = PH_ON;
    end else if (frame_tick) begin
      if (fcnt_inc == FC_LAST) begin
        fcnt_n  = '0;
        phase_n = (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        fcnt_n  = fcnt_inc;
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_sel
    assign sel_n[i] = (idx_n == 2'(i)) && (div_n >= GUARD) && (phase_n == PH_ON);
  end

  assign tick_n = (idx_n == 2'd3) && (div_n == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      started    <= 1'b0;
      div        <= '0;
      digit_idx  <= 2'd0;
      frame_cnt  <= '0;
      phase      <= PH_ON;
      seg        <= SEG_MASK;
      dig_sel    <= DIG_MASK;
      frame_tick <= 1'b0;
    end else begin
      started    <= 1'b1;
      div        <= div_n;
      digit_idx  <= idx_n;
      frame_cnt  <= fcnt_n;
      phase      <= phase_n;
      if (slot_start) seg <= hex[idx_n] ^ SEG_MASK;
      dig_sel    <= sel_n ^ DIG_MASK;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a slot/frame arithmetic model pushes
// expected outputs per cycle; each scenario task pops and compares.
module tb_seg_scan_driver;
  localparam int SD = 8, BG = 2, BD = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [0:3][7:0] hex;
  logic            blink_en;
  logic [7:0]      seg;
  logic [3:0]      dig_sel;
  logic [1:0]      digit_idx;
  logic            frame_tick;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_GUARD(BG), .BLINK_DIV(BD),
                    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .hex(hex), .blink_en(blink_en),
    .seg(seg), .dig_sel(dig_sel), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0, passed = 0;
  int         cyc;
  logic [7:0] shown[4];
  logic       m_off;

  // Model of the cycle the next edge produces, from the absolute cycle number.
  task automatic push_expected();
    int   dv, sl, ix, fr;
    exp_t x;
    dv = cyc % SD; sl = cyc / SD; ix = sl % 4; fr = cyc / (4 * SD);
    if (dv == 0) begin
      shown[ix] = hex[ix];
      m_off = blink_en && (((fr / BD) % 2) == 1);
    end
    x.seg  = ~shown[ix];
    x.dig  = (dv >= BG && !m_off) ? ~(4'b0001 << ix) : 4'hF;
    x.idx  = 2'(ix);
    x.tick = (ix == 3) && (dv == SD - 1);
    sb.push_back(x);
  endtask

  task automatic step();
    push_expected();
    @(posedge clk); #1;
    cyc++;
    e = sb.pop_front();
  endtask

  task automatic do_reset(input logic blink);
    reset = 1'b1; blink_en = blink;
    hex = {8'h3F, 8'h06, 8'h5B, 8'h4F};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; cyc = 0; m_off = 1'b0; sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; blink_en = 1'b0;
    hex = {8'h3F, 8'h06, 8'h5B, 8'h4F};
    repeat (2) @(posedge clk);
    #1;
    checks++; if (seg !== 8'hFF) $display("FAIL reset seg got %h exp ff", seg); else passed++;
    checks++; if (dig_sel !== 4'hF) $display("FAIL reset dig_sel got %b exp 1111", dig_sel); else passed++;
    checks++; if (digit_idx !== 2'd0 || frame_tick !== 1'b0)
      $display("FAIL reset idx/tick got %0d/%b exp 0/0", digit_idx, frame_tick); else passed++;
  endtask

  task automatic test_scan();
    do_reset(1'b0);
    for (int n = 0; n < 64; n++) begin
      step();
      checks++; if (seg !== e.seg) $display("FAIL scan seg cyc=%0d got %h exp %h", cyc-1, seg, e.seg); else passed++;
      checks++; if (dig_sel !== e.dig) $display("FAIL scan dig_sel cyc=%0d got %b exp %b", cyc-1, dig_sel, e.dig); else passed++;
      checks++; if (digit_idx !== e.idx) $display("FAIL scan idx cyc=%0d got %0d exp %0d", cyc-1, digit_idx, e.idx); else passed++;
      checks++; if (frame_tick !== e.tick) $display("FAIL scan tick cyc=%0d got %b exp %b", cyc-1, frame_tick, e.tick); else passed++;
      checks++; if ($countones(~dig_sel) > 1) $display("FAIL scan onehot cyc=%0d got %b exp <=1 low", cyc-1, dig_sel); else passed++;
    end
  endtask

  task automatic test_hex_change();
    do_reset(1'b0);
    for (int n = 0; n < 40; n++) begin
      if (cyc == 3) hex[0] = 8'h66;
      step();
      checks++; if (seg !== e.seg) $display("FAIL hexchg seg cyc=%0d got %h exp %h", cyc-1, seg, e.seg); else passed++;
    end
  endtask

  task automatic test_blink();
    do_reset(1'b1);
    for (int n = 0; n < 6 * 4 * SD; n++) begin
      step();
      checks++; if (dig_sel !== e.dig) $display("FAIL blink dig_sel cyc=%0d got %b exp %b", cyc-1, dig_sel, e.dig); else passed++;
    end
  endtask

  task automatic test_blink_drop();
    do_reset(1'b1);
    for (int n = 0; n < 2 * 4 * SD + 40 + 4 * SD; n++) begin
      if (cyc == 2 * 4 * SD + 12) blink_en = 1'b0;
      step();
      checks++; if (dig_sel !== e.dig) $display("FAIL blkdrop dig_sel cyc=%0d got %b exp %b", cyc-1, dig_sel, e.dig); else passed++;
      checks++; if (seg !== e.seg) $display("FAIL blkdrop seg cyc=%0d got %h exp %h", cyc-1, seg, e.seg); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int n = 0; n < 14; n++) begin
      step();
      checks++; if (dig_sel !== e.dig) $display("FAIL rstmid pre dig_sel cyc=%0d got %b exp %b", cyc-1, dig_sel, e.dig); else passed++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (seg !== 8'hFF || dig_sel !== 4'hF)
      $display("FAIL rstmid outs got %h/%b exp ff/1111", seg, dig_sel); else passed++;
    checks++; if (digit_idx !== 2'd0 || frame_tick !== 1'b0 || dut.div !== '0)
      $display("FAIL rstmid state got idx=%0d tick=%b div=%0d exp 0/0/0", digit_idx, frame_tick, dut.div); else passed++;
    reset = 1'b0; cyc = 0; m_off = 1'b0; sb.delete();
    for (int n = 0; n < 16; n++) begin
      step();
      checks++; if (seg !== e.seg || dig_sel !== e.dig || digit_idx !== e.idx)
        $display("FAIL rstmid post cyc=%0d got %h/%b/%0d exp %h/%b/%0d",
                 cyc-1, seg, dig_sel, digit_idx, e.seg, e.dig, e.idx); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex_change();
    test_blink();
    test_blink_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
